// File: rtl/ahb_rr_arbiter.sv
// AHB round-robin bus arbiter with hold limit and locked transfers.
// Define AHB_ARB_SPLIT_EN to compile in SPLIT masking of masters.
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic                   hready,
    input  logic [1:0]             hresp,
    input  logic [NUM_MASTERS-1:0] hsplit,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [MIDX_W-1:0]      hmaster,
    output logic                   hmastlock
);

    typedef enum logic [1:0] {
        ST_PARK   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0]             HOLD_LIM = 8'(MAX_HOLD - 1);
    localparam logic [MIDX_W-1:0]      LAST_RST = MIDX_W'(NUM_MASTERS - 1);
    localparam logic [NUM_MASTERS-1:0] GRANT0   = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [NUM_MASTERS-1:0] NONE     = {NUM_MASTERS{1'b0}};

    state_t                   state_r;
    logic [MIDX_W-1:0]        grant_idx_r;
    logic [NUM_MASTERS-1:0]   hgrant_r;
    logic [MIDX_W-1:0]        last_owner_r;
    logic [7:0]               hold_cnt_r;
    logic [MIDX_W-1:0]        hmaster_r;
    logic                     hmastlock_r;

    logic [NUM_MASTERS-1:0]   elig_s;
    logic [MIDX_W-1:0]        pick_s;
    logic                     keep_s;
    state_t                   nxt_state_s;
    logic [MIDX_W-1:0]        nxt_idx_s;
    logic [MIDX_W-1:0]        nxt_last_s;
    logic [7:0]               nxt_cnt_s;

    // First eligible master scanning upward from last+1 with wrap-around.
    function automatic logic [MIDX_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] elig,
                                                  input logic [MIDX_W-1:0]      last);
        logic             found;
        logic [MIDX_W-1:0] pick;
        int               idx;
        found = 1'b0;
        pick  = {MIDX_W{1'b0}};
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            idx = (int'(last) + k) % NUM_MASTERS;
            if (!found && elig[idx]) begin
                found = 1'b1;
                pick  = idx[MIDX_W-1:0];
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

`ifdef AHB_ARB_SPLIT_EN
    logic [NUM_MASTERS-1:0] split_mask_r;
    logic [NUM_MASTERS-1:0] split_set_s;

    // A SPLIT response parks the data-phase master until its hsplit pulse; set wins.
    always_comb begin
        split_set_s = NONE;
        if (!hready && (hresp == 2'b11)) begin
            split_set_s = GRANT0 << hmaster_r;
        end else begin
            split_set_s = NONE;
        end
    end

    // Split mask register.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            split_mask_r <= NONE;
        end else begin
            split_mask_r <= (split_mask_r & ~hsplit) | split_set_s;
        end
    end

    assign elig_s = hbusreq & ~split_mask_r;
`else
    logic unused_s;
    assign unused_s = ^{hresp, hsplit};
    assign elig_s   = hbusreq;
`endif

    assign pick_s = rr_pick(elig_s, last_owner_r);

    // Next-owner decision evaluated for the next hready-high edge.
    always_comb begin
        keep_s      = 1'b0;
        nxt_state_s = state_r;
        nxt_idx_s   = grant_idx_r;
        nxt_last_s  = last_owner_r;
        nxt_cnt_s   = hold_cnt_r;
        if ((state_r == ST_LOCKED) && hlock[grant_idx_r]) begin
            keep_s = 1'b1;
        end else if ((state_r != ST_PARK) && (|(elig_s & hgrant_r)) &&
                     ((hold_cnt_r < HOLD_LIM) || !(|(elig_s & ~hgrant_r)))) begin
            keep_s = 1'b1;
        end else begin
            keep_s = 1'b0;
        end
        if (keep_s) begin
            nxt_cnt_s   = (hold_cnt_r == 8'hFF) ? hold_cnt_r : hold_cnt_r + 8'd1;
            nxt_state_s = hlock[grant_idx_r] ? ST_LOCKED : ST_OWNED;
        end else if (elig_s == NONE) begin
            nxt_state_s = ST_PARK;
            nxt_idx_s   = {MIDX_W{1'b0}};
            nxt_cnt_s   = 8'd0;
        end else begin
            nxt_idx_s   = pick_s;
            nxt_last_s  = pick_s;
            nxt_cnt_s   = 8'd0;
            nxt_state_s = hlock[pick_s] ? ST_LOCKED : ST_OWNED;
        end
    end

    // Arbitration state advances only on hready-high edges.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_r      <= ST_PARK;
            grant_idx_r  <= {MIDX_W{1'b0}};
            hgrant_r     <= GRANT0;
            last_owner_r <= LAST_RST;
            hold_cnt_r   <= 8'd0;
            hmaster_r    <= {MIDX_W{1'b0}};
            hmastlock_r  <= 1'b0;
        end else if (hready) begin
            state_r      <= nxt_state_s;
            grant_idx_r  <= nxt_idx_s;
            hgrant_r     <= GRANT0 << nxt_idx_s;
            last_owner_r <= nxt_last_s;
            hold_cnt_r   <= nxt_cnt_s;
            hmaster_r    <= grant_idx_r;
            hmastlock_r  <= hlock[grant_idx_r];
        end else begin
            state_r      <= state_r;
            grant_idx_r  <= grant_idx_r;
            hgrant_r     <= hgrant_r;
            last_owner_r <= last_owner_r;
            hold_cnt_r   <= hold_cnt_r;
            hmaster_r    <= hmaster_r;
            hmastlock_r  <= hmastlock_r;
        end
    end

    assign hgrant    = hgrant_r;
    assign hmaster   = hmaster_r;
    assign hmastlock = hmastlock_r;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Randomized bench for ahb_rr_arbiter against a rule-level arbitration model.
// Honours AHB_ARB_SPLIT_EN the same way as the design.
module tb_ahb_rr_arbiter;

    localparam int NM = 4;
    localparam int MH = 4;

    logic          hclk;
    logic          hresetn;
    logic [NM-1:0] hbusreq;
    logic [NM-1:0] hlock;
    logic          hready;
    logic [1:0]    hresp;
    logic [NM-1:0] hsplit;
    logic [NM-1:0] hgrant;
    logic [1:0]    hmaster;
    logic          hmastlock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            m_owner;
    int            m_last;
    int            m_cnt;
    bit            m_parked;
    bit            m_locked;
    int            m_hmaster;
    bit            m_hmastlock;
    logic [NM-1:0] m_mask;

    ahb_rr_arbiter #(.NUM_MASTERS(NM), .MIDX_W(2), .MAX_HOLD(MH)) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .hready    (hready),
        .hresp     (hresp),
        .hsplit    (hsplit),
        .hgrant    (hgrant),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the rules of one rising edge to the model using the inputs driven at it.
    task automatic model_edge(input logic [NM-1:0] br, input logic [NM-1:0] lk, input logic rdy,
                              input logic [1:0] rs, input logic [NM-1:0] sp, input logic rn);
        logic [NM-1:0] elig;
        logic [NM-1:0] others;
        int            pick;
        if (!rn) begin
            m_owner = 0; m_last = NM - 1; m_cnt = 0; m_parked = 1'b1; m_locked = 1'b0;
            m_hmaster = 0; m_hmastlock = 1'b0; m_mask = '0;
            return;
        end
        elig = br & ~m_mask;
`ifdef AHB_ARB_SPLIT_EN
        begin
            logic [NM-1:0] setb;
            setb = '0;
            if (!rdy && rs == 2'b11) setb[m_hmaster] = 1'b1;
            m_mask = (m_mask & ~sp) | setb;
        end
`endif
        if (!rdy) return;
        m_hmaster   = m_owner;
        m_hmastlock = lk[m_owner];
        others = elig;
        others[m_owner] = 1'b0;
        if ((m_locked && lk[m_owner]) ||
            (!m_parked && elig[m_owner] && (m_cnt < MH - 1 || others == '0))) begin
            m_cnt    = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_locked = lk[m_owner];
        end else if (elig == '0) begin
            m_owner = 0; m_cnt = 0; m_parked = 1'b1; m_locked = 1'b0;
        end else begin
            pick = -1;
            for (int k = 1; k <= NM; k++) begin
                if (pick < 0 && elig[(m_last + k) % NM]) pick = (m_last + k) % NM;
            end
            m_owner = pick; m_last = pick; m_cnt = 0; m_parked = 1'b0; m_locked = lk[pick];
        end
    endtask

    task automatic step(input logic [NM-1:0] br, input logic [NM-1:0] lk, input logic rdy,
                        input logic [1:0] rs, input logic [NM-1:0] sp, input logic rn);
        hbusreq = br; hlock = lk; hready = rdy; hresp = rs; hsplit = sp; hresetn = rn;
        @(posedge hclk);
        model_edge(br, lk, rdy, rs, sp, rn);
        #1;
        chk("model_hgrant", 32'(hgrant), 32'(4'b0001 << m_owner));
        chk("model_hmaster", 32'(hmaster), 32'(m_hmaster));
        chk("model_hmastlock", 32'(hmastlock), 32'(m_hmastlock));
    endtask

    initial begin
        hbusreq = '0; hlock = '0; hready = 1'b1; hresp = 2'b00; hsplit = '0; hresetn = 1'b0;
        @(negedge hclk);

        // Reset then idle: parked on master 0
        step(4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b0);
        chk("rst_hgrant", 32'(hgrant), 32'h1);
        chk("rst_hmaster", 32'(hmaster), 32'h0);
        step(4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b1);
        chk("park_hgrant", 32'(hgrant), 32'h1);

        // All request: rotation 0,1,2,3,0 with four cycles each
        step(4'b1111, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk("rot_hgrant", 32'(hgrant), 32'(1 << ((i / 4) % 4)));
            if (i > 0) chk("rot_hmaster", 32'(hmaster), 32'(((i - 1) / 4) % 4));
            step(4'b1111, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b1);
        end

        // Locked owner 2 keeps the bus against full contention
        step(4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b0);
        step(4'b0100, 4'b0100, 1'b1, 2'b00, 4'b0000, 1'b1);
        chk("lock_grant", 32'(hgrant), 32'h4);
        for (int i = 0; i < 40; i++) begin
            step(4'b1111, 4'b0100, 1'b1, 2'b00, 4'b0000, 1'b1);
            chk("lock_hold", 32'(hgrant), 32'h4);
            chk("lock_mastlock", 32'(hmastlock), 32'h1);
            chk("lock_hmaster", 32'(hmaster), 32'h2);
        end
        step(4'b1111, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b1);
        chk("unlock_grant", 32'(hgrant), 32'h8);
        chk("unlock_mastlock", 32'(hmastlock), 32'h0);

        // Handover requested during wait states
        step(4'b0000, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b0);
        step(4'b0001, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0010, 4'b0000, 1'b0, 2'b00, 4'b0000, 1'b1);
            chk("wait_hold", 32'(hgrant), 32'h1);
        end
        step(4'b0010, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b1);
        chk("wait_grant", 32'(hgrant), 32'h2);
        chk("wait_hmaster_old", 32'(hmaster), 32'h0);
        step(4'b0010, 4'b0000, 1'b1, 2'b00, 4'b0000, 1'b1);
        chk("wait_hmaster_new", 32'(hmaster), 32'h1);

        // Random traffic including wait states, responses, split pulses and resets
        for (int i = 0; i < 3000; i++) begin
            logic [NM-1:0] br, lk, sp;
            logic          rdy, rn;
            logic [1:0]    rs;
            br  = NM'($urandom);
            lk  = NM'($urandom) & NM'($urandom) & br;
            rdy = ($urandom_range(0, 4) != 0);
            rs  = 2'($urandom);
            sp  = ($urandom_range(0, 7) == 0) ? NM'($urandom) : '0;
            rn  = ($urandom_range(0, 99) != 0);
            step(br, lk, rdy, rs, sp, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
